oled_frame_scheduler: RTL and testbench
=======================================

Name: oled_frame_scheduler

Overview:
- Frame-refresh sequencer for the 128x64 OLED panel (8 pages x 128 columns).
- Walks page/column and drives col_all/row_all into the glyph address mappers and ROM mux.
- Captures the returned ROM byte and streams page-address command bytes plus data bytes to the serial transmitter over a valid/ready handshake.
- One instance per screen region; COL_BASE selects the region, e.g. 128 or 384.

Parameters:
- COL_BASE, 128: offset added to the local column (0..127) to form col_all.
- PAGES, 8: pages per frame; row_all counts 0..PAGES-1.
- COLS, 128: data bytes per page.
- ROM_LAT, 1: cycles from col_all/row_all change to valid rom_data (1..3).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse after the last data byte is accepted.
- col_all  out  11  COL_BASE + local column, to the address mappers.
- row_all  out  3  current page, to the address mappers.
- rom_data  in  8  glyph byte from the ROM mux, ROM_LAT cycles after the address.
- tx_data  out  8  byte to the transmitter.
- tx_dc  out  1  0 = command byte, 1 = display data byte.
- tx_valid  out  1  tx_data/tx_dc are valid.
- tx_ready  in  1  transmitter accepts when tx_valid && tx_ready on a rising clk.

Behaviour:
- Reset, asynchronous on rst_n low, to these values: state IDLE; busy=0, done=0, tx_valid=0, tx_data=0, tx_dc=0, row_all=0, col_all=COL_BASE; all counters 0.
- Reset mid-frame abandons the frame immediately; no done pulse follows.
- FSM states:
  - IDLE: start=1 -> CMD with cmd_idx=0, page=0, busy=1 next cycle.
  - CMD: present the command byte, dc=0, tx_valid=1. Byte by cmd_idx: 0 -> 0xB0|page; 1 -> 0x00 (low column nibble); 2 -> 0x10 (high column nibble).
  - CMD on handshake: cmd_idx<2 -> cmd_idx+1. cmd_idx=2 -> ADDR with col=0.
  - ADDR: tx_valid=0. Drive row_all=page, col_all=COL_BASE+col. Hold ROM_LAT cycles (wait counter), then register rom_data into tx_data, set tx_dc=1, go to DATA.
  - DATA: tx_valid=1.
  - DATA on handshake with col<COLS-1: col+1, go to ADDR.
  - DATA on handshake with col=COLS-1 and page<PAGES-1: page+1, cmd_idx=0, go to CMD.
  - DATA on handshake with col=COLS-1 and page=PAGES-1: go to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle, tx_valid=0, then IDLE; busy=0 from that IDLE cycle.
- Handshake rules:
  - While tx_valid && !tx_ready, tx_data/tx_dc/col_all/row_all stay stable.
  - tx_valid never drops without a handshake, except on reset.
- col_all/row_all hold their last value outside ADDR/DATA. A new byte is never presented in the cycle of the preceding handshake, so the minimum spacing is ROM_LAT+1 cycles per data byte.
- start while busy is ignored: no restart, no queuing.
- start in the DONE cycle is ignored. start in IDLE is accepted, including the cycle immediately after DONE.
- Widths:
  - col_all = COL_BASE + {4'b0, col[6:0]}, unsigned, 11 bits. COL_BASE+COLS-1 must be <= 2047; no wrap is generated.
  - row_all = page[2:0].
- Per frame: PAGES*(3+COLS) handshakes = 1048 with defaults.
- Minimum frame time with tx_ready tied high:
  - 24 CMD cycles, plus 1024*(ROM_LAT+1) ADDR+DATA cycles, plus 1 DONE cycle.
  - The IDLE cycle in which start is sampled is not counted.
  - With defaults: 2073 cycles from the first CMD cycle through DONE.

Test Plan:
- Reset: hold rst_n=0 with start toggling -> busy=0, done=0, tx_valid=0, col_all=128, row_all=0. Release reset -> outputs stay idle until start.
- Full frame, tx_ready=1, ROM model returns {row_all,col_all[4:0]}:
  - exactly 1048 handshakes;
  - first bytes B0/00/10 with dc=0;
  - data bytes equal the model for col_all 128..255;
  - page 7 header is B7/00/10;
  - single-cycle done, 2073 cycles from the first CMD cycle.
- Backpressure: tx_ready random 30% duty -> tx_data/tx_dc/col_all/row_all stable while stalled, byte sequence identical to the unstalled frame.
- start pulsed at handshake 500 and again in the DONE cycle -> ignored, no second frame. start in the IDLE cycle after DONE -> a new frame begins.
- Reset mid-frame: assert rst_n=0 during page 3 DATA with tx_valid=1 -> tx_valid drops asynchronously, no done. A following start -> frame restarts at B0.
- ROM_LAT=3, COL_BASE=384 -> col_all spans 384..511, each data byte presented 3 cycles after the address, data matches the ROM model.

Source files
------------

// File: rtl/oled_frame_scheduler.sv
// -----------------------------------------------------------------------------
// oled_frame_scheduler
//
// Frame-refresh sequencer for one region of a 128x64 OLED panel. For each of
// PAGES pages it sends a three-byte page-address header (0xB0|page, 0x00,
// 0x10), then walks COLS columns. For each column it drives col_all/row_all
// to the glyph address mappers, waits ROM_LAT cycles for the ROM mux, latches
// rom_data and sends it as a display-data byte. A one-cycle done pulse ends
// the frame.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           one-cycle pulse, begins a frame when idle
//   busy            high from the first header cycle through the done cycle
//   done            one-cycle pulse after the last data byte is accepted
//   col_all[10:0]   COL_BASE + local column, to the address mappers
//   row_all[2:0]    current page, to the address mappers
//   rom_data[7:0]   glyph byte; sampled on the clock edge that ends the
//                   ROM_LAT-th address cycle
//   tx_data[7:0]    byte to the serial transmitter
//   tx_dc           0 = command byte, 1 = display data byte
//   tx_valid        tx_data/tx_dc are valid
//   tx_ready        transmitter ready
//   fsm_state[2:0]  current FSM state (debug observation)
//
// Handshake: a byte transfers on a rising clk edge where tx_valid && tx_ready.
// While tx_valid is high and tx_ready is low, tx_data, tx_dc, col_all and
// row_all hold steady, and tx_valid only drops after a transfer (or reset).
// -----------------------------------------------------------------------------
module oled_frame_scheduler #(
  parameter int COL_BASE = 128,
  parameter int PAGES    = 8,
  parameter int COLS     = 128,
  parameter int ROM_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [10:0] col_all,
  output logic [2:0]  row_all,
  input  logic [7:0]  rom_data,
  output logic [7:0]  tx_data,
  output logic        tx_dc,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [6:0]  COL_LAST  = 7'(COLS - 1);
  localparam logic [2:0]  PAGE_LAST = 3'(PAGES - 1);
  localparam logic [1:0]  WAIT_LAST = 2'(ROM_LAT - 1);
  localparam logic [10:0] BASE      = 11'(COL_BASE);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cmd_idx;
  logic [6:0] col;
  logic [6:0] col_inc;
  logic [2:0] page;
  logic [2:0] page_inc;
  logic [1:0] wait_cnt;
  logic       hs;
  logic       wait_done;

  assign hs        = tx_valid && tx_ready;
  assign wait_done = (wait_cnt == WAIT_LAST);
  assign col_inc   = col + 7'd1;
  assign page_inc  = page + 3'd1;

  // Outputs decoded straight from the state register, so reset clears
  // tx_valid/busy asynchronously together with the state.
  assign tx_valid  = (state == S_CMD) || (state == S_DATA);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_CMD;
      S_CMD:  if (hs && cmd_idx == 2'd2) state_nxt = S_ADDR;
      S_ADDR: if (wait_done) state_nxt = S_DATA;
      S_DATA: begin
        if (hs) begin
          if (col != COL_LAST)        state_nxt = S_ADDR;
          else if (page != PAGE_LAST) state_nxt = S_CMD;
          else                        state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Datapath. tx_data/tx_dc are loaded only on the transition that presents
  // a new byte, and col_all/row_all only on entry to ADDR, so everything the
  // transmitter or mappers see is frozen while a byte is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_idx  <= 2'd0;
      col      <= 7'd0;
      page     <= 3'd0;
      wait_cnt <= 2'd0;
      tx_data  <= 8'h00;
      tx_dc    <= 1'b0;
      col_all  <= BASE;
      row_all  <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cmd_idx <= 2'd0;
            page    <= 3'd0;
            tx_data <= 8'hB0;
            tx_dc   <= 1'b0;
          end
        end
        S_CMD: begin
          if (hs) begin
            case (cmd_idx)
              2'd0: begin
                cmd_idx <= 2'd1;
                tx_data <= 8'h00;
              end
              2'd1: begin
                cmd_idx <= 2'd2;
                tx_data <= 8'h10;
              end
              default: begin
                col      <= 7'd0;
                wait_cnt <= 2'd0;
                col_all  <= BASE;
                row_all  <= page;
              end
            endcase
          end
        end
        S_ADDR: begin
          if (wait_done) begin
            tx_data <= rom_data;
            tx_dc   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (hs) begin
            if (col != COL_LAST) begin
              col      <= col_inc;
              wait_cnt <= 2'd0;
              col_all  <= BASE + {4'b0, col_inc};
            end else if (page != PAGE_LAST) begin
              page    <= page_inc;
              cmd_idx <= 2'd0;
              tx_data <= 8'hB0 | {5'b0, page_inc};
              tx_dc   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_oled_frame_scheduler
//
// Two scheduler instances: u_dut with default parameters and a combinational
// ROM model ({row_all, col_all[4:0]}), and u_dut2 with ROM_LAT=3, COL_BASE=384
// and a two-stage registered ROM model of the same function. Expected byte
// sequences are pushed into queues when a frame is started; monitors pop and
// compare on every transmitter handshake.
// -----------------------------------------------------------------------------
module tb_oled_frame_scheduler;

  localparam int W = 23;  // {dc, byte, row[2:0], col[10:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance 1 (defaults) ----------------
  logic        start = 1'b0;
  logic        busy, done, tx_dc, tx_valid;
  logic        tx_ready = 1'b1;
  logic [10:0] col_all;
  logic [2:0]  row_all, fsm_state;
  logic [7:0]  rom_data, tx_data;

  assign rom_data = {row_all, col_all[4:0]};

  oled_frame_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .col_all(col_all), .row_all(row_all), .rom_data(rom_data),
    .tx_data(tx_data), .tx_dc(tx_dc), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .fsm_state(fsm_state)
  );

  // ---------------- instance 2 (ROM_LAT=3, COL_BASE=384) ----------------
  logic        start2 = 1'b0;
  logic        busy2, done2, tx_dc2, tx_valid2;
  logic        tx_ready2 = 1'b1;
  logic [10:0] col_all2;
  logic [2:0]  row_all2, fsm_state2;
  logic [7:0]  rom_data2, tx_data2, rom_p1, rom_p2;

  always @(posedge clk) begin
    rom_p1 <= {row_all2, col_all2[4:0]};
    rom_p2 <= rom_p1;
  end
  assign rom_data2 = rom_p2;

  oled_frame_scheduler #(.COL_BASE(384), .ROM_LAT(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .col_all(col_all2), .row_all(row_all2), .rom_data(rom_data2),
    .tx_data(tx_data2), .tx_dc(tx_dc2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .fsm_state(fsm_state2)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q2[$];
  int n_tests = 0;
  int n_fail  = 0;
  int hs_count = 0, hs2_count = 0;
  int busy_cycles = 0, busy2_cycles = 0;
  int done_count = 0;
  bit rand_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Expected frame: per page a three-byte header, then one data byte per column
  task automatic push_frame(input bit which, input int base);
    logic [W-1:0] e;
    logic [10:0]  a;
    logic [2:0]   p3;
    for (int p = 0; p < 8; p++) begin
      p3 = 3'(p);
      for (int k = 0; k < 3; k++) begin
        case (k)
          0:       e = {1'b0, 8'hB0 | {5'b0, p3}, 14'd0};
          1:       e = {1'b0, 8'h00, 14'd0};
          default: e = {1'b0, 8'h10, 14'd0};
        endcase
        if (which) exp_q2.push_back(e); else exp_q.push_back(e);
      end
      for (int c = 0; c < 128; c++) begin
        a = 11'(base + c);
        e = {1'b1, p3, a[4:0], p3, a};
        if (which) exp_q2.push_back(e); else exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input bit which);
    @(negedge clk);
    if (which) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int limit);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      #1;
      seen = which ? done2 : done;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: inst=%0d no done within %0d cycles", which, limit);
    end
  endtask

  // Ready driver: changes just after the rising edge, so monitors see it stable
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // ---------------- monitor, instance 1 ----------------
  logic         stalled = 1'b0;
  logic [7:0]   s_data;
  logic         s_dc;
  logic [10:0]  s_col;
  logic [2:0]   s_row;
  logic [W-1:0] got_e, exp_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        n_tests++;
        if (!tx_valid || tx_data !== s_data || tx_dc !== s_dc ||
            col_all !== s_col || row_all !== s_row) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b d=%0h dc=%0b col=%0d row=%0d expected v=1 d=%0h dc=%0b col=%0d row=%0d",
                   tx_valid, tx_data, tx_dc, col_all, row_all, s_data, s_dc, s_col, s_row);
        end
      end
      if (tx_valid && tx_ready) begin
        hs_count++;
        n_tests++;
        got_e = {tx_dc, tx_data, tx_dc ? {row_all, col_all} : 14'd0};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL byte_unexpected: got=%0h expected=none", got_e);
        end else begin
          exp_e = exp_q.pop_front();
          if (got_e !== exp_e) begin
            n_fail++;
            $display("FAIL byte[%0d]: got=%0h expected=%0h", hs_count - 1, got_e, exp_e);
          end
        end
      end
      stalled = tx_valid && !tx_ready;
      s_data  = tx_data;
      s_dc    = tx_dc;
      s_col   = col_all;
      s_row   = row_all;
      if (busy) busy_cycles++;
      if (done) done_count++;
    end
  end

  // ---------------- monitor, instance 2 ----------------
  int           cyc2 = 0, hs_cyc2 = 0;
  logic         prev_v2 = 1'b0;
  logic [W-1:0] got2, exp2;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v2 = 1'b0;
    end else begin
      cyc2++;
      if (tx_valid2 && tx_dc2 && !prev_v2) begin
        check("addr_to_data_latency", 32'(cyc2 - (hs_cyc2 + 1)), 32'd3);
      end
      if (tx_valid2 && tx_ready2) begin
        hs2_count++;
        hs_cyc2 = cyc2;
        n_tests++;
        got2 = {tx_dc2, tx_data2, tx_dc2 ? {row_all2, col_all2} : 14'd0};
        if (exp_q2.size() == 0) begin
          n_fail++;
          $display("FAIL byte2_unexpected: got=%0h expected=none", got2);
        end else begin
          exp2 = exp_q2.pop_front();
          if (got2 !== exp2) begin
            n_fail++;
            $display("FAIL byte2[%0d]: got=%0h expected=%0h", hs2_count - 1, got2, exp2);
          end
        end
      end
      if (busy2) busy2_cycles++;
      prev_v2 = tx_valid2;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int saved, dcnt;
    bit found;

    // Reset held with start toggling
    repeat (4) begin
      @(negedge clk);
      start  = ~start;
      start2 = ~start2;
    end
    #1;
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_done",     32'(done),      32'd0);
    check("rst_tx_valid", 32'(tx_valid),  32'd0);
    check("rst_col_all",  32'(col_all),   32'd128);
    check("rst_row_all",  32'(row_all),   32'd0);
    check("rst_tx_data",  32'(tx_data),   32'd0);
    check("rst_tx_dc",    32'(tx_dc),     32'd0);
    check("rst_state",    32'(fsm_state), 32'd0);
    check("rst_col_all2", 32'(col_all2),  32'd384);
    start  = 1'b0;
    start2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("idle_after_rst_busy",  32'(busy),     32'd0);
    check("idle_after_rst_valid", 32'(tx_valid), 32'd0);

    // Frame 1: tx_ready high
    push_frame(1'b0, 128);
    busy_cycles = 0;
    hs_count    = 0;
    pulse_start(1'b0);
    wait_done(1'b0, 3000);
    check("f1_frame_cycles", 32'(busy_cycles), 32'd2073);
    check("f1_handshakes",   32'(hs_count),    32'd1048);
    check("f1_queue_empty",  32'(exp_q.size()), 32'd0);
    check("f1_done_busy",    32'(busy),        32'd1);
    check("f1_done_valid",   32'(tx_valid),    32'd0);

    // Frame 2: start in the IDLE cycle right after DONE, random backpressure
    rand_mode = 1'b1;
    push_frame(1'b0, 128);
    busy_cycles = 0;
    hs_count    = 0;
    @(negedge clk);
    #1;
    check("f1_done_single", 32'(done), 32'd0);
    check("f1_idle_busy",   32'(busy), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("f2_started", 32'(busy), 32'd1);
    for (int k = 0; k < 20000 && hs_count < 500; k++) @(negedge clk);
    check("f2_reached_500", 32'(hs_count >= 500), 32'd1);
    #1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 20000);
    start = 1'b1;  // start in the DONE cycle
    check("f2_handshakes",  32'(hs_count),      32'd1048);
    check("f2_queue_empty", 32'(exp_q.size()),  32'd0);
    @(negedge clk);
    start = 1'b0;
    rand_mode = 1'b0;
    #1;
    check("f2_idle_busy", 32'(busy), 32'd0);
    saved = busy_cycles;
    repeat (20) @(negedge clk);
    #1;
    check("no_restart", 32'(busy_cycles), 32'(saved));

    // Frame 3: reset during page 3 DATA
    push_frame(1'b0, 128);
    hs_count = 0;
    pulse_start(1'b0);
    found = 1'b0;
    for (int k = 0; k < 5000 && !found; k++) begin
      @(negedge clk);
      #1;
      found = tx_valid && tx_dc && (row_all == 3'd3);
    end
    check("f3_reached_page3", 32'(found), 32'd1);
    dcnt  = done_count;
    rst_n = 1'b0;
    #1;
    check("f3_async_valid", 32'(tx_valid), 32'd0);
    check("f3_async_busy",  32'(busy),     32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("f3_no_done", 32'(done_count), 32'(dcnt));
    check("f3_idle",    32'(busy),       32'd0);

    // Frame 4: fresh frame after the abandoned one
    push_frame(1'b0, 128);
    busy_cycles = 0;
    hs_count    = 0;
    pulse_start(1'b0);
    wait_done(1'b0, 3000);
    check("f4_frame_cycles", 32'(busy_cycles),  32'd2073);
    check("f4_handshakes",   32'(hs_count),     32'd1048);
    check("f4_queue_empty",  32'(exp_q.size()), 32'd0);

    // Frame 5: instance 2, ROM_LAT=3, COL_BASE=384
    push_frame(1'b1, 384);
    busy2_cycles = 0;
    hs2_count    = 0;
    pulse_start(1'b1);
    wait_done(1'b1, 6000);
    check("f5_frame_cycles", 32'(busy2_cycles),  32'd4121);
    check("f5_handshakes",   32'(hs2_count),     32'd1048);
    check("f5_queue_empty",  32'(exp_q2.size()), 32'd0);
    @(negedge clk);
    #1;
    check("f5_idle", 32'(busy2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
